serial_bit_tx: RTL and testbench

SERIAL_BIT_TX -- requirements
Module: serial_bit_tx

---
 rtl/serial_bit_tx_pkg.sv | 16 +
 rtl/sclk_tick_gen.sv | 28 ++
 rtl/serial_bit_tx.sv | 111 +++++++++++
 tb/tb_serial_bit_tx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_bit_tx_pkg.sv
// Shared types and default constants for the serial_bit_tx word serialiser.
package serial_bit_tx_pkg;

  localparam int DEFAULT_DATA_W  = 8;
  localparam int DEFAULT_CLK_DIV = 4;

  // Wide enough to count the data bits plus an optional parity bit.
  localparam int BIT_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } tx_state_e;

endpackage

// File: rtl/sclk_tick_gen.sv
// Phase timer for serial_bit_tx: pulses phase_end once every CLK_DIV enabled cycles.
module sclk_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  output logic phase_end
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  // Held at zero while disabled so every frame starts on a fresh phase.
  always_ff @(posedge clk) begin
    if (!resetn || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign phase_end = en && (cnt == LAST);

endmodule

// File: rtl/serial_bit_tx.sv
// Parallel-to-serial transmitter driving a D flip-flop chain (sclk/sdata/sload), MSB first.
// Optional even-parity bit after the LSB when SERIAL_BIT_TX_PARITY_EN is defined.
module serial_bit_tx
  import serial_bit_tx_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              sclk,
  output logic              sdata,
  output logic              sload,
  output logic              busy
);

`ifdef SERIAL_BIT_TX_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(NBITS - 1);

  tx_state_e            state, state_nxt;
  logic [NBITS-1:0]     shreg, shreg_nxt;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic                 sclk_q, sclk_nxt;
  logic                 phase_end;
  logic [NBITS-1:0]     load_word;

`ifdef SERIAL_BIT_TX_PARITY_EN
  assign load_word = {tx_data, ^tx_data};
`else
  assign load_word = tx_data;
`endif

  sclk_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk      (clk),
    .resetn   (resetn),
    .en       (state != IDLE),
    .phase_end(phase_end)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    sclk_nxt    = sclk_q;
    unique case (state)
      IDLE: begin
        if (tx_valid) begin
          state_nxt   = SHIFT;
          shreg_nxt   = load_word;
          bit_cnt_nxt = '0;
          sclk_nxt    = 1'b0;
        end
      end
      SHIFT: begin
        if (phase_end) begin
          if (!sclk_q) begin
            sclk_nxt = 1'b1;
          end else begin
            // Falling sclk is the only point where sdata may move.
            sclk_nxt = 1'b0;
            if (bit_cnt == LAST_BIT) begin
              state_nxt = LATCH;
            end else begin
              bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
              shreg_nxt   = shreg << 1;
            end
          end
        end
      end
      LATCH: begin
        if (phase_end) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so all flops update together.
    if (!resetn) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      sclk_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      sclk_q  <= sclk_nxt;
    end
  end

  assign tx_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign sclk     = sclk_q;
  assign sdata    = (state == SHIFT) && shreg[NBITS-1];
  assign sload    = (state == LATCH);

endmodule

// File: tb/tb_serial_bit_tx.sv
// Scoreboard bench for serial_bit_tx: lane 0 is DATA_W=8/CLK_DIV=2, lane 1 is DATA_W=4/CLK_DIV=1.
module tb_serial_bit_tx;

`ifdef SERIAL_BIT_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  typedef struct {
    logic [32:0] word;
    int          nbits;
    int          len;
    int          sload_len;
    bit          abort;
    int          gap;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic [7:0] tx_data[2];
  logic       tx_valid[2];
  logic       rdy0, sclk0, sdata0, sload0, busy0;
  logic       rdy1, sclk1, sdata1, sload1, busy1;

  serial_bit_tx #(.DATA_W(8), .CLK_DIV(2)) dut (
    .clk(clk), .resetn(resetn), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(rdy0), .sclk(sclk0), .sdata(sdata0), .sload(sload0), .busy(busy0)
  );

  serial_bit_tx #(.DATA_W(4), .CLK_DIV(1)) dut_b (
    .clk(clk), .resetn(resetn), .tx_data(tx_data[1][3:0]), .tx_valid(tx_valid[1]),
    .tx_ready(rdy1), .sclk(sclk1), .sdata(sdata1), .sload(sload1), .busy(busy1)
  );

  // Behavioural receiver chains clocked by each sclk.
  logic [32:0] chain0 = '0;
  logic [32:0] chain1 = '0;
  always @(posedge sclk0) chain0 <= {chain0[31:0], sdata0};
  always @(posedge sclk1) chain1 <= {chain1[31:0], sdata1};

  logic        rdy[2], sclk_w[2], sdata_w[2], sload_w[2], busy_w[2];
  logic [32:0] chain_w[2];
  assign rdy[0] = rdy0;     assign rdy[1] = rdy1;
  assign sclk_w[0] = sclk0; assign sclk_w[1] = sclk1;
  assign sdata_w[0] = sdata0; assign sdata_w[1] = sdata1;
  assign sload_w[0] = sload0; assign sload_w[1] = sload1;
  assign busy_w[0] = busy0; assign busy_w[1] = busy1;
  assign chain_w[0] = chain0; assign chain_w[1] = chain1;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[2][$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int lane_dw(input int ln);
    return (ln == 0) ? 8 : 4;
  endfunction

  function automatic int lane_cd(input int ln);
    return (ln == 0) ? 2 : 1;
  endfunction

  function automatic exp_t make_exp(input int ln, input logic [7:0] d, input bit abort, input int gap);
    exp_t        e;
    logic [31:0] w;
    w = 32'(d) & ((32'd1 << lane_dw(ln)) - 32'd1);
    e.word      = (PAR == 1) ? {w, ^w} : {1'b0, w};
    e.nbits     = lane_dw(ln) + PAR;
    e.len       = (2 * e.nbits + 1) * lane_cd(ln);
    e.sload_len = lane_cd(ln);
    e.abort     = abort;
    e.gap       = gap;
    return e;
  endfunction

  // Monitor: pops an expectation at each frame start and checks it as the frame plays out.
  bit   mon_en = 1'b0;
  bit   act[2];
  exp_t cur[2];

  initial begin
    bit prev_busy[2];
    bit prev_sclk[2];
    int len[2], rises[2], sl[2], idle[2];
    for (int i = 0; i < 2; i++) begin
      prev_busy[i] = 1'b0; prev_sclk[i] = 1'b0; act[i] = 1'b0;
      len[i] = 0; rises[i] = 0; sl[i] = 0; idle[i] = 0;
    end
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int i = 0; i < 2; i++) begin
          check($sformatf("ready_vs_busy%0d", i), rdy[i], !busy_w[i]);
          if (busy_w[i] && !prev_busy[i]) begin
            if (exp_q[i].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_frame lane=%0d actual=frame required=none", i);
              act[i] = 1'b0;
            end else begin
              cur[i] = exp_q[i].pop_front();
              act[i] = 1'b1;
              if (cur[i].gap >= 0) check($sformatf("idle_gap%0d", i), idle[i], cur[i].gap);
            end
            len[i] = 0; rises[i] = 0; sl[i] = 0;
          end
          if (busy_w[i]) begin
            idle[i] = 0;
            len[i]++;
            if (sclk_w[i] && !prev_sclk[i]) rises[i]++;
            if (sload_w[i]) begin
              if (sl[i] == 0 && act[i] && !cur[i].abort)
                check($sformatf("chain_word%0d", i),
                      chain_w[i] & ((33'd1 << cur[i].nbits) - 33'd1), cur[i].word);
              sl[i]++;
            end
          end else begin
            idle[i]++;
            check($sformatf("idle_outputs%0d", i), {sclk_w[i], sdata_w[i], sload_w[i]}, 3'b000);
            if (prev_busy[i] && act[i]) begin
              if (cur[i].abort) begin
                check($sformatf("abort_no_sload%0d", i), sl[i], 0);
              end else begin
                check($sformatf("frame_len%0d", i), len[i], cur[i].len);
                check($sformatf("sclk_rises%0d", i), rises[i], cur[i].nbits);
                check($sformatf("sload_len%0d", i), sl[i], cur[i].sload_len);
              end
              act[i] = 1'b0;
            end
          end
          prev_busy[i] = busy_w[i];
          prev_sclk[i] = sclk_w[i];
        end
      end
    end
  end

  task automatic wait_ready(input int ln);
    int n = 0;
    while (!rdy[ln] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[ln]) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout lane=%0d actual=0 required=1", ln);
    end
  endtask

  task automatic wait_done(input int ln);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #1;
      if (!busy_w[ln] && !act[ln] && exp_q[ln].size() == 0) return;
    end
    checks++;
    errors++;
    $display("FAIL done_timeout lane=%0d actual=busy required=idle", ln);
  endtask

  // Sends one word, then scrambles tx_data so a late capture would corrupt the frame.
  task automatic send(input int ln, input logic [7:0] d, input bit abort);
    exp_q[ln].push_back(make_exp(ln, d, abort, -1));
    @(negedge clk);
    tx_data[ln]  = d;
    tx_valid[ln] = 1'b1;
    wait_ready(ln);
    @(posedge clk);
    #1;
    tx_valid[ln] = 1'b0;
    tx_data[ln]  = ~d;
  endtask

  initial begin
    int r;
    bit ps;
    resetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tx_data[i]  = '0;
      tx_valid[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    check("reset_state0", {rdy0, busy0, sclk0, sdata0, sload0}, 5'b10000);
    check("reset_state1", {rdy1, busy1, sclk1, sdata1, sload1}, 5'b10000);
    mon_en = 1'b1;

    // 0xA5 on lane 0: bits 1,0,1,0,0,1,0,1, 34-cycle frame without parity.
    send(0, 8'hA5, 1'b0);
    wait_done(0);

    // Held tx_valid: 0x3C then 0xC3, second accepted on the single IDLE cycle.
    exp_q[0].push_back(make_exp(0, 8'h3C, 1'b0, -1));
    exp_q[0].push_back(make_exp(0, 8'hC3, 1'b0, 1));
    @(negedge clk);
    tx_data[0]  = 8'h3C;
    tx_valid[0] = 1'b1;
    wait_ready(0);
    @(posedge clk);
    #1;
    tx_data[0] = 8'hC3;
    wait_ready(0);
    @(posedge clk);
    #1;
    tx_valid[0] = 1'b0;
    tx_data[0]  = 8'h55;
    wait_done(0);

    // 0xFF aborted by a one-cycle reset just after the 3rd sclk rise; lane 1 tx_valid during reset.
    send(0, 8'hFF, 1'b1);
    r  = 0;
    ps = 1'b0;
    for (int c = 0; c < 200 && r < 3; c++) begin
      @(negedge clk);
      if (sclk0 && !ps) r++;
      ps = sclk0;
    end
    check("rises_before_reset", r, 3);
    resetn      = 1'b0;
    tx_data[1]  = 8'h0F;
    tx_valid[1] = 1'b1;
    @(negedge clk);
    resetn      = 1'b1;
    tx_valid[1] = 1'b0;
    check("abort_state0", {rdy0, busy0, sclk0, sdata0, sload0}, 5'b10000);
    check("reset_ignores_valid", busy1, 1'b0);
    r  = 0;
    ps = sclk0;
    repeat (6) begin
      @(negedge clk);
      if (sclk0 && !ps) r++;
      ps = sclk0;
    end
    check("no_sclk_after_abort", r, 0);

    send(0, 8'h01, 1'b0);
    wait_done(0);

    // 0x07: the last bit on the chain is 1 (parity when enabled, data LSB otherwise).
    send(0, 8'h07, 1'b0);
    wait_done(0);
    check("last_bit_07", chain0[0], 1'b1);

    // Lane 1, CLK_DIV=1: 0x9 -> 1,0,0,1, sclk = clk/2, 9-cycle frame without parity.
    send(1, 8'h09, 1'b0);
    wait_done(1);
    check("chain_09", chain1[3 + PAR:PAR], 4'h9);

    repeat (4) @(negedge clk);
    check("queue0_empty", exp_q[0].size(), 0);
    check("queue1_empty", exp_q[1].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
